mem_port_arbiter: RTL and testbench

- Shares the single 256-bit main-memory port (the DRAM/AXI-side `mem_req_*` / `mem_resp_*` interface) between NUM_REQ cached-CPU or loader requesters.
- Round-robin grant; one transaction outstanding; responses are routed back to the granted requester.
- Sits between the cached CPU instances' memory ports and the memory model or AXI bridge in the SoC top.

---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/rr_priority_pick.sv | 28 ++
 rtl/mem_port_arbiter.sv | 172 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the main-memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    RESP  = 2'd2
  } arb_state_e;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 256;
  localparam int TO_CNT_W   = 16;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: first set request scanning ptr+1, ptr+2, ... modulo N.
module rr_priority_pick #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);

  logic [IW-1:0] cand;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(ptr_i) + k) % N);
      if (!found_o && req_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one main-memory port between NUM_REQ requesters, one transaction in flight.
// Optional watchdog enabled by defining MEM_ARB_TIMEOUT_EN (adds output timeout_err_o).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int NUM_REQ        = 2,
  parameter  int ADDR_W         = DEF_ADDR_W,
  parameter  int DATA_W         = DEF_DATA_W,
  parameter  int TIMEOUT_CYCLES = 1024,
  localparam int ID_W           = $clog2(NUM_REQ)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ-1:0]        req_we_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  output logic [NUM_REQ-1:0]        resp_valid_o,
  output logic [DATA_W-1:0]         resp_data_o,
  output logic                      mem_req_valid_o,
  output logic [ADDR_W-1:0]         mem_req_addr_o,
  output logic                      mem_req_we_o,
  output logic [DATA_W-1:0]         mem_req_data_o,
  input  logic                      mem_resp_valid_i,
  input  logic [DATA_W-1:0]         mem_resp_data_i,
`ifdef MEM_ARB_TIMEOUT_EN
  output logic                      timeout_err_o,
`endif
  output logic                      busy_o,
  output logic [ID_W-1:0]           grant_id_o
);

  arb_state_e          state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]     grant_id_q, grant_id_d;
  logic                mem_req_valid_q, mem_req_valid_d;
  logic [ADDR_W-1:0]   mem_req_addr_q, mem_req_addr_d;
  logic                mem_req_we_q, mem_req_we_d;
  logic [DATA_W-1:0]   mem_req_data_q, mem_req_data_d;
  logic [NUM_REQ-1:0]  resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]   resp_data_q, resp_data_d;
  logic                busy_q, busy_d;

  logic                pick_found;
  logic [ID_W-1:0]     pick_idx;
  logic [ADDR_W-1:0]   addr_arr [NUM_REQ];
  logic [DATA_W-1:0]   data_arr [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_arr[i] = req_addr_i[i*ADDR_W +: ADDR_W];
      data_arr[i] = req_data_i[i*DATA_W +: DATA_W];
    end
  end

  rr_priority_pick #(.N(NUM_REQ)) u_pick (
    .req_i   (req_valid_i),
    .ptr_i   (rr_ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

`ifdef MEM_ARB_TIMEOUT_EN
  logic [TO_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic                timeout_err_q, timeout_err_d;
`endif

  always_comb begin
    state_d         = state_q;
    rr_ptr_d        = rr_ptr_q;
    grant_id_d      = grant_id_q;
    mem_req_valid_d = mem_req_valid_q;
    mem_req_addr_d  = mem_req_addr_q;
    mem_req_we_d    = mem_req_we_q;
    mem_req_data_d  = mem_req_data_q;
    resp_valid_d    = '0;
    resp_data_d     = resp_data_q;
`ifdef MEM_ARB_TIMEOUT_EN
    wait_cnt_d      = wait_cnt_q;
    timeout_err_d   = timeout_err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          rr_ptr_d        = pick_idx;
          grant_id_d      = pick_idx;
          mem_req_valid_d = 1'b1;
          mem_req_addr_d  = addr_arr[pick_idx];
          mem_req_we_d    = req_we_i[pick_idx];
          mem_req_data_d  = data_arr[pick_idx];
          state_d         = GRANT;
`ifdef MEM_ARB_TIMEOUT_EN
          wait_cnt_d      = '0;
`endif
        end
      end
      GRANT: begin
        if (mem_resp_valid_i) begin
          resp_data_d     = mem_resp_data_i;
          resp_valid_d    = NUM_REQ'(1) << grant_id_q;
          mem_req_valid_d = 1'b0;
          state_d         = RESP;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        // Watchdog: complete the transaction with zero data so the requester is released.
        else if (wait_cnt_q == TO_CNT_W'(TIMEOUT_CYCLES - 1)) begin
          resp_data_d     = '0;
          resp_valid_d    = NUM_REQ'(1) << grant_id_q;
          mem_req_valid_d = 1'b0;
          timeout_err_d   = 1'b1;
          state_d         = RESP;
        end else begin
          wait_cnt_d      = wait_cnt_q + 1'b1;
        end
`endif
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= IDLE;
      rr_ptr_q        <= ID_W'(NUM_REQ - 1);
      grant_id_q      <= '0;
      mem_req_valid_q <= 1'b0;
      mem_req_addr_q  <= '0;
      mem_req_we_q    <= 1'b0;
      mem_req_data_q  <= '0;
      resp_valid_q    <= '0;
      resp_data_q     <= '0;
      busy_q          <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      wait_cnt_q      <= '0;
      timeout_err_q   <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      rr_ptr_q        <= rr_ptr_d;
      grant_id_q      <= grant_id_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_req_addr_q  <= mem_req_addr_d;
      mem_req_we_q    <= mem_req_we_d;
      mem_req_data_q  <= mem_req_data_d;
      resp_valid_q    <= resp_valid_d;
      resp_data_q     <= resp_data_d;
      busy_q          <= busy_d;
`ifdef MEM_ARB_TIMEOUT_EN
      wait_cnt_q      <= wait_cnt_d;
      timeout_err_q   <= timeout_err_d;
`endif
    end
  end

  assign resp_valid_o    = resp_valid_q;
  assign resp_data_o     = resp_data_q;
  assign mem_req_valid_o = mem_req_valid_q;
  assign mem_req_addr_o  = mem_req_addr_q;
  assign mem_req_we_o    = mem_req_we_q;
  assign mem_req_data_o  = mem_req_data_q;
  assign busy_o          = busy_q;
  assign grant_id_o      = grant_id_q;
`ifdef MEM_ARB_TIMEOUT_EN
  assign timeout_err_o   = timeout_err_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (two requesters, timeout limit 8 when enabled).
module tb_mem_port_arbiter;

  localparam int NR = 2;
  localparam int AW = 32;
  localparam int DW = 256;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR*AW-1:0]  req_addr;
  logic [NR-1:0]     req_we;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     resp_valid;
  logic [DW-1:0]     resp_data;
  logic              mem_req_valid;
  logic [AW-1:0]     mem_req_addr;
  logic              mem_req_we;
  logic [DW-1:0]     mem_req_data;
  logic              mem_resp_valid;
  logic [DW-1:0]     mem_resp_data;
  logic              busy;
  logic [0:0]        grant_id;
`ifdef MEM_ARB_TIMEOUT_EN
  logic              timeout_err;
`endif

  int total = 0;
  int bad   = 0;

  localparam logic [AW-1:0] ADDR0 = 32'h0000_1000;
  localparam logic [AW-1:0] ADDR1 = 32'h0000_2000;
  localparam logic [DW-1:0] PAT_AA = {32{8'hAA}};
  localparam logic [DW-1:0] PAT_55 = {32{8'h55}};
  localparam logic [DW-1:0] PAT_77 = {32{8'h77}};

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .req_valid_i      (req_valid),
    .req_addr_i       (req_addr),
    .req_we_i         (req_we),
    .req_data_i       (req_data),
    .resp_valid_o     (resp_valid),
    .resp_data_o      (resp_data),
    .mem_req_valid_o  (mem_req_valid),
    .mem_req_addr_o   (mem_req_addr),
    .mem_req_we_o     (mem_req_we),
    .mem_req_data_o   (mem_req_data),
    .mem_resp_valid_i (mem_resp_valid),
    .mem_resp_data_i  (mem_resp_data),
`ifdef MEM_ARB_TIMEOUT_EN
    .timeout_err_o    (timeout_err),
`endif
    .busy_o           (busy),
    .grant_id_o       (grant_id)
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "bench timed out");
  end

  initial begin
    logic [0:0]    exp_id;
    logic [AW-1:0] exp_addr;

    rst_n          = 1'b0;
    req_valid      = 2'b01;
    req_addr       = {ADDR1, ADDR0};
    req_we         = 2'b00;
    req_data       = '0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;

    // Test 1: reset values, then first grant and read response for requester 0.
    tick();
    check("rst_mem_req_valid", DW'(mem_req_valid), DW'(1'b0));
    check("rst_mem_req_addr",  DW'(mem_req_addr),  '0);
    check("rst_busy",          DW'(busy),          DW'(1'b0));
    check("rst_grant_id",      DW'(grant_id),      '0);
    check("rst_resp_valid",    DW'(resp_valid),    '0);
    check("rst_resp_data",     resp_data,          '0);
    rst_n = 1'b1;
    tick();
    check("t1_mem_req_valid", DW'(mem_req_valid), DW'(1'b1));
    check("t1_mem_req_addr",  DW'(mem_req_addr),  DW'(ADDR0));
    check("t1_grant_id",      DW'(grant_id),      '0);
    check("t1_busy",          DW'(busy),          DW'(1'b1));
    mem_resp_valid = 1'b1;
    mem_resp_data  = PAT_AA;
    tick();
    check("t1_resp_valid",     DW'(resp_valid),    DW'(2'b01));
    check("t1_resp_data",      resp_data,          PAT_AA);
    check("t1_mem_req_valid0", DW'(mem_req_valid), DW'(1'b0));
    mem_resp_valid = 1'b0;
    req_valid      = 2'b00;
    tick();
    check("t1_resp_clear", DW'(resp_valid), '0);
    check("t1_idle_busy",  DW'(busy),       DW'(1'b0));

    // Test 2: both requesters always valid, four-cycle memory latency; last winner was 0.
    req_valid = 2'b11;
    exp_id    = 1'b0;
    for (int n = 0; n < 4; n++) begin
      exp_id   = ~exp_id;
      exp_addr = (exp_id == 1'b0) ? ADDR0 : ADDR1;
      tick();
      check("t2_grant_id",      DW'(grant_id),      DW'(exp_id));
      check("t2_mem_req_addr",  DW'(mem_req_addr),  DW'(exp_addr));
      for (int w = 0; w < 3; w++) begin
        tick();
        check("t2_hold_valid", DW'(mem_req_valid), DW'(1'b1));
        check("t2_hold_addr",  DW'(mem_req_addr),  DW'(exp_addr));
      end
      mem_resp_valid = 1'b1;
      mem_resp_data  = DW'(n + 1);
      tick();
      check("t2_resp_valid", DW'(resp_valid), DW'(2'b01) << exp_id);
      check("t2_resp_data",  resp_data,       DW'(n + 1));
      mem_resp_valid = 1'b0;
      tick();
    end
    req_valid = 2'b00;

    // Test 3: write from requester 1 (last winner was 0, so 1 is next anyway).
    tick();
    req_valid = 2'b10;
    req_we    = 2'b10;
    req_data  = {PAT_55, PAT_AA};
    tick();
    check("t3_grant_id",     DW'(grant_id),     DW'(1'b1));
    check("t3_mem_req_we",   DW'(mem_req_we),   DW'(1'b1));
    check("t3_mem_req_data", mem_req_data,      PAT_55);
    check("t3_mem_req_addr", DW'(mem_req_addr), DW'(ADDR1));
    mem_resp_valid = 1'b1;
    mem_resp_data  = '0;
    tick();
    check("t3_resp_valid", DW'(resp_valid), DW'(2'b10));
    mem_resp_valid = 1'b0;
    req_valid      = 2'b00;
    req_we         = 2'b00;
    tick();
    check("t3_resp_clear", DW'(resp_valid), '0);

    // Test 4: asynchronous reset in the middle of GRANT.
    req_valid = 2'b01;
    tick();
    check("t4_in_grant", DW'(mem_req_valid), DW'(1'b1));
    #2 rst_n = 1'b0;
    #1;
    check("t4_async_valid", DW'(mem_req_valid), DW'(1'b0));
    check("t4_async_busy",  DW'(busy),          DW'(1'b0));
    req_valid = 2'b00;
    #1 rst_n = 1'b1;
    mem_resp_valid = 1'b1;
    mem_resp_data  = PAT_AA;
    tick();
    check("t4_stale_resp", DW'(resp_valid), '0);
    check("t4_stale_data", resp_data,       '0);
    mem_resp_valid = 1'b0;

    // Test 5: memory response while IDLE is ignored; arbiter still grants afterwards (ptr reset to 1).
    mem_resp_valid = 1'b1;
    mem_resp_data  = PAT_55;
    tick();
    check("t5_idle_resp", DW'(resp_valid), '0);
    check("t5_idle_busy", DW'(busy),       DW'(1'b0));
    mem_resp_valid = 1'b0;
    req_valid      = 2'b11;
    tick();
    check("t5_grant_id", DW'(grant_id),     '0);
    check("t5_addr",     DW'(mem_req_addr), DW'(ADDR0));
    mem_resp_valid = 1'b1;
    mem_resp_data  = PAT_77;
    tick();
    check("t5_resp_valid", DW'(resp_valid), DW'(2'b01));
    check("t5_resp_data",  resp_data,       PAT_77);
    mem_resp_valid = 1'b0;
    req_valid      = 2'b00;
    tick();

`ifdef MEM_ARB_TIMEOUT_EN
    // Test 6: no memory response; watchdog fires after 8 GRANT cycles.
    req_valid = 2'b01;
    tick();
    check("t6_grant", DW'(mem_req_valid), DW'(1'b1));
    for (int i = 1; i < 8; i++) begin
      tick();
      check("t6_wait_valid", DW'(mem_req_valid), DW'(1'b1));
      check("t6_wait_resp",  DW'(resp_valid),    '0);
    end
    tick();
    check("t6_to_resp_valid", DW'(resp_valid),    DW'(2'b01));
    check("t6_to_resp_data",  resp_data,          '0);
    check("t6_to_err",        DW'(timeout_err),   DW'(1'b1));
    check("t6_to_mem_valid",  DW'(mem_req_valid), DW'(1'b0));
    req_valid = 2'b00;
    tick();
    mem_resp_valid = 1'b1;
    tick();
    check("t6_late_resp", DW'(resp_valid),  '0);
    check("t6_err_sticky", DW'(timeout_err), DW'(1'b1));
    mem_resp_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t6_err_reset", DW'(timeout_err), DW'(1'b0));
    rst_n = 1'b1;
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
